// File: rtl/boundary_counter_nd.sv
// DIMS-dimensional inclusive box scanner (dimension 0 innermost) with handshaked bounds loading.
// Optional macro BOUNDARY_COUNTER_ND_CONTINUOUS_EN: the scan restarts from min after the last tuple.
module boundary_counter_nd #(
  parameter  int MAX_COUNT = 1024,
  parameter  int DIMS      = 2,
  localparam int CW        = $clog2(MAX_COUNT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               bounds_valid_in,
  input  logic [DIMS*CW-1:0] min_in,
  input  logic [DIMS*CW-1:0] max_in,
  output logic               bounds_ready_out,
  output logic               bounds_err_out,
  input  logic               start_in,
  input  logic               abort_in,
  input  logic               advance_in,
  output logic               valid_out,
  output logic [DIMS*CW-1:0] count_out,
  output logic [DIMS-1:0]    wrap_out,
  output logic               last_out,
  output logic               busy_out
);

`ifdef BOUNDARY_COUNTER_ND_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DIMS*CW-1:0] min_q, max_q, count_q, count_next;
  logic [DIMS-1:0]    wrap;
  logic               err_q, bounds_ok, load_req, load_ok, transfer, at_last, carry;

  assign load_req = (state_q == IDLE) && bounds_valid_in;
  assign load_ok  = load_req && bounds_ok;
  assign transfer = (state_q == RUN) && advance_in;
  assign at_last  = &wrap;

  always_comb begin
    bounds_ok = 1'b1;
    for (int d = 0; d < DIMS; d++) begin
      if (min_in[d*CW +: CW] > max_in[d*CW +: CW]) bounds_ok = 1'b0;
    end
  end

  // Carry chain: a dimension steps only while every inner dimension sits at its max.
  always_comb begin
    carry      = 1'b1;
    count_next = count_q;
    for (int d = 0; d < DIMS; d++) begin
      if (carry) begin
        if (wrap[d]) begin
          count_next[d*CW +: CW] = min_q[d*CW +: CW];
        end else begin
          count_next[d*CW +: CW] = count_q[d*CW +: CW] + CW'(1);
          carry                  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_in) state_d = RUN;
      RUN:  if (abort_in || (transfer && at_last && !CONTINUOUS)) state_d = IDLE;
    endcase
  end

  // A start in the same cycle as an accepted load scans the freshly loaded box.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= load_req && !bounds_ok;
      if (load_ok) begin
        min_q <= min_in;
        max_q <= max_in;
      end
      if (state_q == IDLE) begin
        if (start_in) count_q <= load_ok ? min_in : min_q;
      end else if (transfer && !abort_in && (!at_last || CONTINUOUS)) begin
        count_q <= count_next;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < DIMS; d++) begin
      wrap[d] = (count_q[d*CW +: CW] == max_q[d*CW +: CW]);
    end
    valid_out        = (state_q == RUN);
    busy_out         = (state_q == RUN);
    bounds_ready_out = (state_q == IDLE);
    last_out         = (state_q == RUN) && at_last;
  end

  assign wrap_out       = wrap;
  assign count_out      = count_q;
  assign bounds_err_out = err_q;

endmodule

// File: tb/tb_boundary_counter_nd.sv
// Scoreboard bench for boundary_counter_nd: a nested-loop box model queues expected tuples,
// a negedge monitor checks each presented tuple and retires it on every transfer.
module tb_boundary_counter_nd;
  localparam int MAX_COUNT = 16;
  localparam int DIMS      = 2;
  localparam int CW        = 4;
  localparam int W         = DIMS * CW;

  logic          clk_in = 1'b0;
  logic          rst_in, bounds_valid_in, start_in, abort_in, advance_in;
  logic [W-1:0]  min_in, max_in, count_out;
  logic          bounds_ready_out, bounds_err_out, valid_out, last_out, busy_out;
  logic [DIMS-1:0] wrap_out;

  boundary_counter_nd #(.MAX_COUNT(MAX_COUNT), .DIMS(DIMS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bounds_valid_in(bounds_valid_in),
    .min_in(min_in), .max_in(max_in), .bounds_ready_out(bounds_ready_out),
    .bounds_err_out(bounds_err_out), .start_in(start_in), .abort_in(abort_in),
    .advance_in(advance_in), .valid_out(valid_out), .count_out(count_out),
    .wrap_out(wrap_out), .last_out(last_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0]    cnt;
    logic [DIMS-1:0] wrap;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  exp_t first_exp, last_exp;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_x0 = 0, m_y0 = 0, m_x1 = 0, m_y1 = 0;
  bit   mon_en = 1'b0;

  task automatic checkOutput(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the box in row-major order, x innermost.
  task automatic pushScan();
    exp_t e;
    for (int y = m_y0; y <= m_y1; y++) begin
      for (int x = m_x0; x <= m_x1; x++) begin
        e.cnt  = {CW'(y), CW'(x)};
        e.wrap = {(y == m_y1), (x == m_x1)};
        e.last = (x == m_x1) && (y == m_y1);
        if (x == m_x0 && y == m_y0) first_exp = e;
        if (e.last) last_exp = e;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input bit bv, input int x0, input int y0,
                               input int x1, input int y1, input bit st);
    bit ok;
    bounds_valid_in = bv;
    min_in          = {CW'(y0), CW'(x0)};
    max_in          = {CW'(y1), CW'(x1)};
    start_in        = st;
    @(posedge clk_in); #1;
    bounds_valid_in = 1'b0;
    start_in        = 1'b0;
    ok = (x0 <= x1) && (y0 <= y1);
    if (bv && ok) begin
      m_x0 = x0; m_y0 = y0; m_x1 = x1; m_y1 = y1;
    end
    checkOutput("bounds_err", int'(bounds_err_out), int'(bv && !ok));
    if (st) begin
      checkOutput("start_valid", int'(valid_out), 1);
      pushScan();
    end
  endtask

  task automatic abortScan();
    abort_in   = 1'b1;
    advance_in = 1'($urandom_range(0, 1));
    @(posedge clk_in); #1;
    abort_in   = 1'b0;
    advance_in = 1'b0;
    exp_q.delete();
    checkOutput("abort_valid", int'(valid_out), 0);
    checkOutput("abort_busy", int'(busy_out), 0);
    checkOutput("abort_ready", int'(bounds_ready_out), 1);
  endtask

  // mode 0: advance held high, 1: random advance, 2: repeating 1,0,0,1,0,1
  task automatic runUntilDrained(input int mode);
    int     cyc = 0;
    bit [5:0] pat = 6'b101001;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       advance_in = 1'b1;
        1:       advance_in = ($urandom_range(0, 2) != 0);
        default: advance_in = pat[cyc % 6];
      endcase
      @(posedge clk_in); #1;
      cyc++;
    end
    advance_in = 1'b0;
    if (exp_q.size() > 0) begin
      checkOutput("scan_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
`ifdef BOUNDARY_COUNTER_ND_CONTINUOUS_EN
    checkOutput("cont_valid_held", int'(valid_out), 1);
    exp_q.push_back(first_exp);
    abortScan();
`else
    checkOutput("end_valid", int'(valid_out), 0);
    checkOutput("end_ready", int'(bounds_ready_out), 1);
    checkOutput("end_count_hold", int'(count_out), int'(last_exp.cnt));
`endif
  endtask

  always @(negedge clk_in) begin
    if (mon_en && valid_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("mon_unexpected_valid", 1, 0);
      end else begin
        checkOutput("mon_count", int'(count_out), int'(exp_q[0].cnt));
        checkOutput("mon_wrap", int'(wrap_out), int'(exp_q[0].wrap));
        checkOutput("mon_last", int'(last_out), int'(exp_q[0].last));
        if (advance_in) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst_in = 1'b1; bounds_valid_in = 1'b0; start_in = 1'b0;
    abort_in = 1'b0; advance_in = 1'b0; min_in = '0; max_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rst_valid", int'(valid_out), 0);
    checkOutput("rst_busy", int'(busy_out), 0);
    checkOutput("rst_ready", int'(bounds_ready_out), 1);
    checkOutput("rst_err", int'(bounds_err_out), 0);
    checkOutput("rst_count", int'(count_out), 0);
    checkOutput("rst_last", int'(last_out), 0);
    rst_in = 1'b0;
    mon_en = 1'b1;

    $display("[TB] basic scan (2,1)..(4,2)");
    applyStimulus(1'b1, 2, 1, 4, 2, 1'b1);
    runUntilDrained(0);

    $display("[TB] stalled scan with advance pattern");
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    runUntilDrained(2);

    $display("[TB] rejected bounds load");
    applyStimulus(1'b1, 5, 1, 3, 2, 1'b0);
    @(posedge clk_in); #1;
    checkOutput("err_pulse_width", int'(bounds_err_out), 0);
    applyStimulus(1'b1, 5, 1, 3, 2, 1'b1);
    bounds_valid_in = 1'b1;
    min_in          = {CW'(2), CW'(5)};
    max_in          = {CW'(1), CW'(3)};
    advance_in      = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("run_load_bad_err", int'(bounds_err_out), 0);
    min_in = {CW'(0), CW'(0)};
    max_in = {CW'(1), CW'(1)};
    @(posedge clk_in); #1;
    checkOutput("run_load_good_err", int'(bounds_err_out), 0);
    bounds_valid_in = 1'b0;
    runUntilDrained(1);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    runUntilDrained(0);

    $display("[TB] abort at (3,1)");
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    advance_in = 1'b1;
    @(posedge clk_in); #1;
    advance_in = 1'b0;
    checkOutput("abort_at_count", int'(count_out), int'({CW'(1), CW'(3)}));
    abortScan();

    $display("[TB] reset mid-scan at (2,2)");
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    advance_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    advance_in = 1'b0;
    checkOutput("pre_reset_count", int'(count_out), int'({CW'(2), CW'(2)}));
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    exp_q.delete();
    m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
    checkOutput("midrst_valid", int'(valid_out), 0);
    checkOutput("midrst_count", int'(count_out), 0);
    checkOutput("midrst_ready", int'(bounds_ready_out), 1);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
    runUntilDrained(0);

    $display("[TB] degenerate box (7,7)");
    applyStimulus(1'b1, 7, 7, 7, 7, 1'b1);
    runUntilDrained(1);

    $display("[TB] randomized boxes");
    for (int i = 0; i < 12; i++) begin
      int x0, y0, x1, y1, t;
      x0 = int'($urandom_range(0, MAX_COUNT - 1));
      y0 = int'($urandom_range(0, MAX_COUNT - 1));
      x1 = x0 + int'($urandom_range(0, (MAX_COUNT - 1 - x0) > 4 ? 4 : (MAX_COUNT - 1 - x0)));
      y1 = y0 + int'($urandom_range(0, (MAX_COUNT - 1 - y0) > 4 ? 4 : (MAX_COUNT - 1 - y0)));
      if ($urandom_range(0, 3) == 0) begin
        t = x0; x0 = x1; x1 = t;
      end
      applyStimulus(1'b1, x0, y0, x1, y1, 1'b1);
      runUntilDrained(1);
    end

    repeat (2) @(posedge clk_in);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
